// File: rtl/ac_div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states,
// the saturated quotient constant and counter sizing.
package ac_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Quotient returned for divide-by-zero and overflow; sliced to WIDTH at use.
  localparam logic [63:0] QUOT_SAT_ALL = '1;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/ac_div_step.sv
// One combinational restoring-division iteration: shift in the next dividend
// bit, trial-subtract the divisor, keep the difference when it is non-negative.
module ac_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] pr_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] pr_out,
  output logic             qbit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff_low;

  always_comb begin
    shifted  = {pr_in, dvd_bit};
    // The remainder is always below the divisor, so the low WIDTH bits of the
    // difference are the full result whenever the subtraction succeeds.
    diff_low = shifted[WIDTH-1:0] - divisor;
    qbit     = (shifted >= {1'b0, divisor});
    pr_out   = qbit ? diff_low : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/ac_div_seq.sv
// Sequential restoring divider (2*WIDTH / WIDTH) with ready/valid handshakes
// and optional truncation of the low quotient iterations.
module ac_div_seq
  import ac_div_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TRUNC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quot,
  output logic [WIDTH-1:0]   rem,
  output logic               ovf,
  output logic               div0
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - TRUNC);
  localparam logic [WIDTH-1:0] QUOT_SAT = QUOT_SAT_ALL[WIDTH-1:0];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] pr_q, pr_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] qacc_q, qacc_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             ovf_q, ovf_d;
  logic             div0_q, div0_d;

  logic [WIDTH-1:0] step_pr;
  logic             step_qbit;

  ac_div_step #(.WIDTH(WIDTH)) u_step (
    .pr_in   (pr_q),
    .dvd_bit (dvd_q[WIDTH-1]),
    .divisor (dvs_q),
    .pr_out  (step_pr),
    .qbit    (step_qbit)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pr_d      = pr_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    qacc_d    = qacc_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    ovf_d     = ovf_q;
    div0_d    = div0_q;
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          pr_d    = dividend[2*WIDTH-1:WIDTH];
          dvd_d   = dividend[WIDTH-1:0];
          dvs_d   = divisor;
          count_d = CNT_LOAD;
          qacc_d  = '0;
          ovf_d   = 1'b0;
          div0_d  = 1'b0;
          if (divisor == '0) begin
            quot_d  = QUOT_SAT;
            rem_d   = dividend[WIDTH-1:0];
            div0_d  = 1'b1;
            state_d = ST_DONE;
          end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
            quot_d  = QUOT_SAT;
            rem_d   = '0;
            ovf_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        pr_d    = step_pr;
        dvd_d   = dvd_q << 1;
        qacc_d  = (qacc_q << 1) | WIDTH'(step_qbit);
        count_d = count_q - 1'b1;
        if (count_q == CNT_W'(1)) begin
          // Skipped low iterations leave zeros below the computed quotient bits.
          quot_d  = qacc_d << TRUNC;
          rem_d   = step_pr;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      pr_q    <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      qacc_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pr_q    <= pr_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      qacc_q  <= qacc_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      div0_q  <= div0_d;
    end
  end

  assign quot = quot_q;
  assign rem  = rem_q;
  assign ovf  = ovf_q;
  assign div0 = div0_q;

endmodule
